// File: rtl/gpr_sched_pkg.sv
// Shared types and constants for the GPR write-port scheduler.
package gpr_sched_pkg;
  localparam int REG_IDX_W = 5;
  localparam int DW        = 32;

  typedef enum logic {ALU_FIRST, LSU_FIRST} state_t;
  typedef enum logic {SRC_ALU, SRC_LSU} src_t;
endpackage

// File: rtl/gpr_scoreboard.sv
// Pending-load scoreboard: one busy bit per register plus a three-port hazard lookup.
module gpr_scoreboard
  import gpr_sched_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int IW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic [IW-1:0] set_idx,
  input  logic          wr_en,
  input  src_t          wr_src,
  input  logic [IW-1:0] wr_idx,
  input  logic [IW-1:0] q_rs1,
  input  logic [IW-1:0] q_rs2,
  input  logic [IW-1:0] q_ws,
  output logic          hazard
);
  logic [NREGS-1:0] busy;

  // The set is applied after the clear so a same-index collision leaves the bit set.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (wr_en && wr_src == SRC_LSU) busy[wr_idx] <= 1'b0;
      if (set_en && set_idx != '0)     busy[set_idx] <= 1'b1;
    end
  end

  assign hazard = busy[q_rs1] | busy[q_rs2] | busy[q_ws];
endmodule

// File: rtl/gpr_write_scheduler.sv
// Arbitrates the register file write port between ALU writeback and LSU load return.
module gpr_write_scheduler #(
  parameter int NREGS    = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [$clog2(NREGS)-1:0] alu_ws,
  input  logic [DW-1:0]            alu_wd,
  output logic                     alu_ready,
  input  logic                     lsu_valid,
  input  logic [$clog2(NREGS)-1:0] lsu_ws,
  input  logic [DW-1:0]            lsu_wd,
  output logic                     lsu_ready,
  input  logic                     issue_valid,
  input  logic [$clog2(NREGS)-1:0] issue_ws,
  input  logic [$clog2(NREGS)-1:0] q_rs1,
  input  logic [$clog2(NREGS)-1:0] q_rs2,
  input  logic [$clog2(NREGS)-1:0] q_ws,
  output logic                     hazard,
  output logic                     RegWrite,
  output logic [$clog2(NREGS)-1:0] ws,
  output logic [DW-1:0]            wd
);
  import gpr_sched_pkg::*;

  localparam int IW = $clog2(NREGS);

  state_t        state, state_nxt;
  logic [3:0]    wait_cnt, wait_nxt;
  src_t          src;
  logic [IW-1:0] xfer_ws;
  logic [DW-1:0] xfer_wd;

  always_comb begin
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    if (!rst) begin
      if (state == ALU_FIRST) begin
        alu_ready = alu_valid;
        lsu_ready = lsu_valid && !alu_valid;
      end else begin
        lsu_ready = lsu_valid;
        alu_ready = alu_valid && !lsu_valid;
      end
    end
  end

  // Counter saturates so a very long refusal cannot wrap back below MAX_WAIT.
  always_comb begin
    wait_nxt = 4'd0;
    if (lsu_valid && !lsu_ready)
      wait_nxt = (wait_cnt == 4'hF) ? wait_cnt : wait_cnt + 4'd1;
    state_nxt = state;
    case (state)
      ALU_FIRST: if (wait_nxt >= 4'(MAX_WAIT)) state_nxt = LSU_FIRST;
      LSU_FIRST: if (lsu_ready) state_nxt = ALU_FIRST;
      default:   state_nxt = ALU_FIRST;
    endcase
  end

  assign xfer_ws = lsu_ready ? lsu_ws : alu_ws;
  assign xfer_wd = lsu_ready ? lsu_wd : alu_wd;

  // Writes to r0 are accepted but never reach the port, so ws/wd keep their last values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ALU_FIRST;
      wait_cnt <= 4'd0;
      RegWrite <= 1'b0;
      ws       <= '0;
      wd       <= '0;
      src      <= SRC_ALU;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      RegWrite <= 1'b0;
      if ((alu_ready || lsu_ready) && xfer_ws != '0) begin
        RegWrite <= 1'b1;
        ws       <= xfer_ws;
        wd       <= xfer_wd;
        src      <= lsu_ready ? SRC_LSU : SRC_ALU;
      end
    end
  end

  gpr_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (issue_valid),
    .set_idx (issue_ws),
    .wr_en   (RegWrite),
    .wr_src  (src),
    .wr_idx  (ws),
    .q_rs1   (q_rs1),
    .q_rs2   (q_rs2),
    .q_ws    (q_ws),
    .hazard  (hazard)
  );
endmodule

// File: doc/gpr_write_scheduler.md
# gpr_write_scheduler

Schedules the single general-purpose register file write port between the ALU writeback path and the load/store unit (LSU) load-return path. It also keeps a per-register pending-load scoreboard so decode can stall on RAW and WAW hazards. It sits between the execute/memory stages and the register file's RegWrite/ws/wd inputs, with a registered output stage that drives that write port.

## Interface
- NREGS, 32: number of architectural registers; index width is log2(NREGS)=5.
- DW, 32: data width.
- MAX_WAIT, 3: consecutive cycles a valid LSU request may be refused before it takes priority; legal range 1..15.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- alu_valid  in  1  ALU writeback request.
- alu_ws  in  5  ALU destination register.
- alu_wd  in  DW  ALU write data.
- alu_ready  out  1  ALU request granted this cycle; combinational.
- lsu_valid  in  1  load-return writeback request.
- lsu_ws  in  5  load destination register.
- lsu_wd  in  DW  load data.
- lsu_ready  out  1  LSU request granted this cycle; combinational.
- issue_valid  in  1  a load was dispatched this cycle.
- issue_ws  in  5  destination register of the dispatched load.
- q_rs1, q_rs2, q_ws  in  5 each  decode query indices.
- hazard  out  1  any queried register is pending; combinational.
- RegWrite  out  1  register file write enable; registered.
- ws  out  5  register file write index; registered.
- wd  out  DW  register file write data; registered.

## Operation
- Handshake:
  - A transfer occurs when valid && ready.
  - At most one of alu_ready and lsu_ready is high in any cycle.
  - A ready is never asserted without its own valid.
  - A requester holds valid, ws and wd stable until its transfer.
- Priority FSM with two states:
  - ALU_FIRST (reset state): ALU wins if valid; otherwise LSU wins if valid.
  - LSU_FIRST: LSU wins if valid; otherwise ALU wins if valid.
- Wait counter (4 bits):
  - Increments each cycle that lsu_valid && !lsu_ready.
  - Clears on an LSU transfer, and also clears whenever lsu_valid is low.
- FSM transitions:
  - ALU_FIRST -> LSU_FIRST when the counter reaches MAX_WAIT at a clock edge.
  - LSU_FIRST -> ALU_FIRST on an LSU transfer.
- Output stage:
  - A winning transfer loads ws and wd and sets RegWrite=1.
  - RegWrite=0 in any cycle with no transfer.
  - ws and wd hold their last values when RegWrite=0.
- Register 0 is hardwired:
  - A transfer with ws=0 is accepted (ready=1) but produces RegWrite=0.
  - An issue with issue_ws=0 does not set busy[0].
- Scoreboard (busy, NREGS bits):
  - issue_valid sets busy[issue_ws].
  - busy[ws] clears in the cycle the output stage presents RegWrite=1 for a transfer that came from the LSU. The bit clears on the edge after that cycle, so the register file write and the clear take effect together.
  - If a set and a clear hit the same index in the same cycle, the set wins.
- hazard = busy[q_rs1] | busy[q_rs2] | busy[q_ws].

## Timing
- Grant is combinational, in the same cycle as valid.
- The register file write is presented one cycle after the transfer.
- busy is set one cycle after issue_valid and cleared two cycles after the LSU transfer.
- Reset values: RegWrite=0, ws=0, wd=0, busy=0, counter=0, state=ALU_FIRST.
- While rst is high, alu_ready=0 and lsu_ready=0.
- Reset mid-operation: a transfer in the same cycle as rst is discarded, and any write pending in the output stage is dropped, so RegWrite=0 on the next cycle.
- Back-to-back transfers sustain one register file write per cycle.

## Structure
- Shared package gpr_sched_pkg holds:
  - the state enum {ALU_FIRST, LSU_FIRST};
  - the REG_IDX_W=5 and DW=32 constants;
  - the source tag encoding {SRC_ALU, SRC_LSU} used by the output stage to decide whether to clear busy.
- Sub-module gpr_scoreboard contains the busy vector, the set/clear logic and the three-port hazard lookup.
- The top level contains the arbiter FSM, the wait counter and the output stage.

## Test plan
- Reset, then alu_valid with ws=5, wd=0x12345678 -> alu_ready=1 the same cycle; next cycle RegWrite=1, ws=5, wd=0x12345678.
- alu_valid and lsu_valid held together, MAX_WAIT=3 -> ALU is granted 3 times, then LSU on the 4th cycle, then ALU again; no cycle has both readys high.
- issue_valid with issue_ws=7, then q_rs1=7 -> hazard=1 from the next cycle. An LSU transfer to 7 occurs at cycle t -> RegWrite with ws=7 at t+1, hazard=0 at t+2.
- In the same cycle, issue_ws=9 and the output stage presents an LSU write to 9 -> busy[9] stays 1.
- An ALU transfer with ws=0 -> alu_ready=1 and RegWrite stays 0; issue_ws=0 -> hazard with q_rs1=0 stays 0.
- rst asserted in the cycle after a transfer -> RegWrite=0 next cycle; busy, state and counter are back at their reset values.
